// File: rtl/i2c_reg_init_seq_if.sv
// Table, control and open-drain line bundle between the init sequencer and its environment.
// The master modport is the sequencer side; slave is the board/table side.
interface i2c_reg_init_seq_if #(
   parameter int IDX_W = 8
);
   logic             start;
   logic [IDX_W-1:0] reg_idx;
   logic [7:0]       reg_addr;
   logic [7:0]       reg_data;
   logic             sda_i;
   logic             sda_oe;
   logic             scl_oe;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      input  start, reg_addr, reg_data, sda_i,
      output reg_idx, sda_oe, scl_oe, busy, done, err
   );

   modport slave (
      output start, reg_addr, reg_data, sda_i,
      input  reg_idx, sda_oe, scl_oe, busy, done, err
   );
endinterface

// File: rtl/i2c_reg_init_seq.sv
// I2C write-only master: sends NUM_REGS (addr, data) pairs to one slave, retrying NACKed
// entries up to MAX_RETRY times, and reports sticky done/err.
module i2c_reg_init_seq #(
   parameter logic [6:0] SLAVE_ADDR     = 7'h76,
   parameter int         NUM_REGS       = 5,
   parameter int         QUARTER_CYCLES = 188,
   parameter int         MAX_RETRY      = 3,
   parameter int         IDX_W          = 8
) (
   input logic                Clk,
   input logic                Reset_n,
   i2c_reg_init_seq_if.master bus
);
   localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT_LO, S_BIT_HI, S_STOP, S_GAP} state_t;

   state_t           state, state_nxt;
   logic [QW-1:0]    qcnt;
   logic [1:0]       qph;
   logic [4:0]       slot;
   logic [26:0]      shreg;
   logic [3:0]       retry;
   logic             nack;
   logic [IDX_W-1:0] reg_idx;
   logic             busy, done, err;
   logic             sda_oe, scl_oe;
   logic [1:0]       sda_sync;
   logic             tick, end2, end4, ack_slot, last_idx, retry_max;
   logic             sda_nxt, scl_nxt;

   assign tick      = (qcnt == QW'(QUARTER_CYCLES - 1));
   assign end2      = tick && (qph == 2'd1);
   assign end4      = tick && (qph == 2'd3);
   assign ack_slot  = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
   assign last_idx  = (reg_idx == IDX_W'(NUM_REGS - 1));
   assign retry_max = (retry == 4'(MAX_RETRY));

   assign bus.reg_idx = reg_idx;
   assign bus.sda_oe  = sda_oe;
   assign bus.scl_oe  = scl_oe;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.err     = err;

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Line levels are computed from the current state and registered, so every SCL/SDA
   // edge lags its state boundary by exactly one cycle and phase lengths stay exact.
   always_comb begin
      state_nxt = state;
      sda_nxt   = sda_oe;
      scl_nxt   = scl_oe;
      case (state)
         S_IDLE: begin
            sda_nxt = 1'b0;
            scl_nxt = 1'b0;
            if (bus.start) state_nxt = S_START;
         end
         S_START: begin
            sda_nxt = 1'b1;
            scl_nxt = 1'b0;
            if (end2) state_nxt = S_BIT_LO;
         end
         S_BIT_LO: begin
            scl_nxt = 1'b1;
            if (qph == 2'd1) sda_nxt = ~shreg[26];
            if (end2) state_nxt = S_BIT_HI;
         end
         S_BIT_HI: begin
            scl_nxt = 1'b0;
            if (end2) state_nxt = (slot == 5'd26) ? S_STOP : S_BIT_LO;
         end
         S_STOP: begin
            scl_nxt = ~qph[1];
            sda_nxt = (qph != 2'd3);
            if (end4) state_nxt = S_GAP;
         end
         S_GAP: begin
            sda_nxt = 1'b0;
            scl_nxt = 1'b0;
            if (end4)
               state_nxt = ((!nack && last_idx) || (nack && retry_max)) ? S_IDLE : S_START;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         qcnt     <= '0;
         qph      <= '0;
         slot     <= '0;
         shreg    <= '0;
         retry    <= '0;
         nack     <= 1'b0;
         reg_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         sda_oe   <= 1'b0;
         scl_oe   <= 1'b0;
         sda_sync <= 2'b11;
      end else begin
         sda_sync <= {sda_sync[0], bus.sda_i};
         sda_oe   <= sda_nxt;
         scl_oe   <= scl_nxt;

         if (state_nxt != state) begin
            qcnt <= '0;
            qph  <= '0;
         end else if (tick) begin
            qcnt <= '0;
            qph  <= qph + 2'd1;
         end else begin
            qcnt <= qcnt + QW'(1);
         end

         if (state == S_IDLE && bus.start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            reg_idx <= '0;
            retry   <= '0;
         end

         // Latch on the first START cycle so the table has already seen the new reg_idx.
         // ACK positions hold 1 so the shifted bit releases SDA there.
         if (state == S_START && qph == 2'd0 && qcnt == '0) begin
            shreg <= {SLAVE_ADDR, 1'b0, 1'b1, bus.reg_addr, 1'b1, bus.reg_data, 1'b1};
            slot  <= '0;
            nack  <= 1'b0;
         end

         if (state == S_BIT_HI && qph == 2'd0 && tick && ack_slot && sda_sync[1])
            nack <= 1'b1;

         if (state == S_BIT_HI && end2) begin
            shreg <= {shreg[25:0], 1'b0};
            slot  <= slot + 5'd1;
         end

         if (state == S_GAP && end4) begin
            if (!nack) begin
               if (last_idx) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end else begin
                  reg_idx <= reg_idx + IDX_W'(1);
                  retry   <= '0;
               end
            end else if (retry_max) begin
               busy <= 1'b0;
               err  <= 1'b1;
            end else begin
               retry <= retry + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_reg_init_seq.sv
// Bench for i2c_reg_init_seq: a bus monitor decodes frames and drives slave ACK/NACK,
// checking them against a queue-based model of the retry/advance rules.
module tb_i2c_reg_init_seq;
   localparam int         QC = 4;
   localparam int         NR = 2;
   localparam int         MR = 2;
   localparam int         IW = 8;
   localparam logic [6:0] SA = 7'h76;
   localparam int         FRAME_CYC = 118 * QC;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic slave_pull = 1'b0;
   logic [7:0] tbl_a [256];
   logic [7:0] tbl_d [256];

   i2c_reg_init_seq_if #(.IDX_W(IW)) bus();

   i2c_reg_init_seq #(
      .SLAVE_ADDR(SA), .NUM_REGS(NR), .QUARTER_CYCLES(QC), .MAX_RETRY(MR), .IDX_W(IW)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
   );

   always #5 Clk = ~Clk;

   assign bus.reg_addr = tbl_a[bus.reg_idx];
   assign bus.reg_data = tbl_d[bus.reg_idx];
   assign bus.sda_i    = ~bus.sda_oe & ~slave_pull;

   typedef struct { logic [23:0] bytes; int idx; } frame_t;
   typedef struct { logic done; logic err; int idx; int t0; int ncyc; } out_t;

   frame_t     exp_fr[$];
   out_t       exp_out[$];
   logic [2:0] nack_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor + slave: decodes START/bits/STOP from the lines, answers ACK slots from the
   // per-frame NACK mask, and checks frames and sequence outcomes against the queues.
   logic        m_in = 1'b0, m_pscl = 1'b1, m_psda = 1'b1, m_pbusy = 1'b0;
   int          m_nb = 0, m_run = 0;
   logic [26:0] m_bits = '0;
   logic [2:0]  m_mask = '0;

   always @(negedge Clk) begin
      logic scl, sda;
      frame_t f;
      out_t o;
      int el;
      if (!Reset_n) begin
         m_in = 1'b0; m_nb = 0; m_run = 0; slave_pull = 1'b0;
         m_pscl = 1'b1; m_psda = 1'b1; m_pbusy = 1'b0;
      end else begin
         scl = ~bus.scl_oe;
         sda = bus.sda_i;
         if (scl && m_pscl && sda != m_psda) begin
            if (!sda) begin
               chk("start_while_in_frame", {63'd0, m_in}, 64'd0);
               m_in = 1'b1; m_nb = 0;
               m_mask = (nack_q.size() > 0) ? nack_q.pop_front() : 3'd0;
            end else if (m_in) begin
               m_in = 1'b0;
               chk("frame_bits", 64'(m_nb), 64'd27);
               chk("frame_queue_nonempty", {63'd0, exp_fr.size() > 0}, 64'd1);
               if (exp_fr.size() > 0) begin
                  f = exp_fr.pop_front();
                  chk("frame_bytes", {40'd0, m_bits[26:19], m_bits[17:10], m_bits[8:1]},
                      {40'd0, f.bytes});
                  chk("frame_reg_idx", {56'd0, bus.reg_idx}, 64'(f.idx));
               end
            end
         end
         if (scl != m_pscl) begin
            if (m_in) begin
               if (scl)           chk("scl_low_len", 64'(m_run), 64'(2 * QC));
               else if (m_nb > 0) chk("scl_high_len", 64'(m_run), 64'(2 * QC));
            end
            if (scl && m_in && m_nb < 27) begin
               m_bits[26 - m_nb] = sda;
               m_nb++;
            end
            if (!scl && m_in) begin
               case (m_nb)
                  8:       slave_pull = ~m_mask[0];
                  17:      slave_pull = ~m_mask[1];
                  26:      slave_pull = ~m_mask[2];
                  default: slave_pull = 1'b0;
               endcase
            end
            m_run = 1;
         end else begin
            m_run++;
         end
         if (m_pbusy && !bus.busy) begin
            chk("outcome_queue_nonempty", {63'd0, exp_out.size() > 0}, 64'd1);
            if (exp_out.size() > 0) begin
               o = exp_out.pop_front();
               el = cyc - o.t0;
               chk("done", {63'd0, bus.done}, {63'd0, o.done});
               chk("err", {63'd0, bus.err}, {63'd0, o.err});
               chk("final_reg_idx", {56'd0, bus.reg_idx}, 64'(o.idx));
               chk("lines_released", {62'd0, bus.sda_oe, bus.scl_oe}, 64'd0);
               n_cmp++;
               if (el < o.ncyc - 2 || el > o.ncyc + 2) begin
                  n_bad++;
                  $display("FAIL seq_cycles: got %0d expected %0d +-2", el, o.ncyc);
               end
            end
         end
         m_pscl = scl; m_psda = sda; m_pbusy = bus.busy;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Reference: each entry is tried until the slave ACKs or MAX_RETRY extra attempts are
   // spent; every attempt is one 118Q frame.
   task automatic plan(input int ncnt [NR]);
      int  nf = 0;
      bit  e = 1'b0;
      int  ei = NR - 1;
      for (int i = 0; i < NR && !e; i++) begin
         for (int a = 0; a <= MR; a++) begin
            bit nk;
            nk = (a < ncnt[i]);
            exp_fr.push_back('{{SA, 1'b0, tbl_a[i], tbl_d[i]}, i});
            nack_q.push_back(nk ? 3'($urandom_range(1, 7)) : 3'd0);
            nf++;
            if (!nk) break;
            if (a == MR) begin
               e = 1'b1;
               ei = i;
            end
         end
      end
      exp_out.push_back('{!e, e, ei, cyc, nf * FRAME_CYC});
   endtask

   task automatic run(input int ncnt [NR], input int hold, input bit poke);
      int lim;
      int k = 0;
      plan(ncnt);
      lim = exp_out[exp_out.size() - 1].ncyc + 50;
      bus.start = 1'b1;
      cycles(hold);
      bus.start = 1'b0;
      while (exp_out.size() != 0 && k < lim) begin
         if (poke && k == 600) begin
            bus.start = 1'b1;
            cycles(1);
            bus.start = 1'b0;
         end else begin
            cycles(1);
         end
         k++;
      end
      chk("seq_completed_in_budget", 64'(exp_out.size()), 64'd0);
      exp_out.delete();
      cycles(20);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ncnt [NR];
      bus.start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tbl_a[i] = 8'h00;
         tbl_d[i] = 8'h00;
      end
      cycles(3);
      Reset_n = 1'b1;
      cycles(1);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_err", {63'd0, bus.err}, 64'd0);
      chk("rst_reg_idx", {56'd0, bus.reg_idx}, 64'd0);
      chk("rst_sda_oe", {63'd0, bus.sda_oe}, 64'd0);
      chk("rst_scl_oe", {63'd0, bus.scl_oe}, 64'd0);

      tbl_a[0] = 8'h49; tbl_d[0] = 8'hC0;
      tbl_a[1] = 8'h21; tbl_d[1] = 8'h09;
      run('{0, 0}, 1, 1'b0);
      run('{0, 1}, 1, 1'b0);
      run('{5, 0}, 1, 1'b0);

      // Abort mid data byte of entry 0, then a clean sequence.
      plan('{0, 0});
      bus.start = 1'b1;
      cycles(1);
      bus.start = 1'b0;
      cycles(330);
      Reset_n = 1'b0;
      exp_fr.delete();
      exp_out.delete();
      nack_q.delete();
      cycles(1);
      chk("abort_sda_oe", {63'd0, bus.sda_oe}, 64'd0);
      chk("abort_scl_oe", {63'd0, bus.scl_oe}, 64'd0);
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_reg_idx", {56'd0, bus.reg_idx}, 64'd0);
      Reset_n = 1'b1;
      cycles(5);
      run('{0, 0}, 1, 1'b0);

      run('{0, 0}, 3, 1'b1);

      repeat (8) begin
         for (int i = 0; i < NR; i++) begin
            tbl_a[i] = 8'($urandom);
            tbl_d[i] = 8'($urandom);
            ncnt[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         end
         run(ncnt, 1, 1'b0);
      end

      chk("frames_left", 64'(exp_fr.size()), 64'd0);
      chk("nack_plan_left", 64'(nack_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
